// File: rtl/otter_hazard_pkg.sv
// otter_hazard_pkg
// Shared types for the OTTER hazard controller. It holds the scoreboard entry
// layout, the forwarding-select encodings and the RAW match rule used by both
// the scoreboard and the decision logic.
// Register addresses are stored at a fixed width, HZ_ADDR_W. Narrower
// register-file addresses are zero-extended into that width, so an equality
// compare gives the same result at either width.
package otter_hazard_pkg;

  localparam int HZ_ADDR_W = 8;

  typedef logic [HZ_ADDR_W-1:0] hz_addr_t;

  typedef struct packed {
    logic     valid;
    hz_addr_t rd;
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    hz_addr_t rs1;
    hz_addr_t rs2;
    logic     use_rs1;
    logic     use_rs2;
  } hz_entry_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b01;

  // A source depends on an in-flight writer only if the source is really read,
  // the source is not x0, and the entry is a live instruction that writes rd.
  function automatic logic raw_match(input hz_addr_t  src,
                                     input logic      use_src,
                                     input hz_entry_t entry);
    return use_src && (src != '0) && entry.valid && entry.reg_write &&
           (src == entry.rd);
  endfunction

endpackage

// File: rtl/otter_hazard_sb.sv
// otter_hazard_sb
// Shadow scoreboard of the instructions in the E, M and W stages. It is a
// three-deep shift register that moves in step with the pipeline registers.
// Ports:
//   clk, rst  clock; asynchronous active-high reset (clears the valid bits only)
//   hold      freeze: every entry keeps its value
//   bubble    load an invalid entry into E instead of d_entry
//   d_entry   fields of the instruction currently in D
//   e_q, m_q, w_q  current E/M/W entries
module otter_hazard_sb
  import otter_hazard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      hold,
  input  logic      bubble,
  input  hz_entry_t d_entry,
  output hz_entry_t e_q,
  output hz_entry_t m_q,
  output hz_entry_t w_q
);

  // Valid bits are kept apart from the payload, so that reset touches only
  // the valid bits. Bit 0 is E, bit 1 is M and bit 2 is W.
  logic [2:0] vld;
  hz_entry_t  e_r, m_r, w_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (!hold) begin
      vld <= {vld[1], vld[0], d_entry.valid & ~bubble};
    end
  end

  always_ff @(posedge clk) begin
    if (!hold) begin
      w_r <= m_r;
      m_r <= e_r;
      e_r <= d_entry;
    end
  end

  always_comb begin
    e_q       = e_r;
    e_q.valid = vld[0];
    m_q       = m_r;
    m_q.valid = vld[1];
    w_q       = w_r;
    w_q.valid = vld[2];
  end

endmodule

// File: rtl/otter_hazard_ctrl.sv
// otter_hazard_ctrl
// Hazard controller for the 5-stage OTTER pipeline (F, D, E, M, W). From its
// own E/M/W scoreboard it generates the following:
//   - E-stage forwarding selects
//   - load-use (or no-forward RAW) stalls
//   - taken-branch flushes
//   - a whole-pipe freeze while a data-memory access waits
// It also keeps saturating performance counters.
// Ports:
//   CLK, RST            clock; asynchronous active-high reset
//   d_*                 decoded fields of the instruction in D
//   e_branch_taken      E resolved a taken branch/jump
//   dmem_ready          the M-stage memory access completes this cycle
//   stall_f, stall_d    hold PC / FD register
//   flush_d, flush_e    bubble FD / DE register
//   freeze              hold DE, EM, MW registers
//   fwd_a, fwd_b        E operand selects (00 regfile, 10 M ALU, 01 W data)
//   cnt_stall/flush/retire  saturating event counters
module otter_hazard_ctrl
  import otter_hazard_pkg::*;
#(
  parameter int RF_ADDR_W  = 5,
  parameter int ENABLE_FWD = 1,
  parameter int CNT_W      = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 d_valid,
  input  logic [RF_ADDR_W-1:0] d_rs1,
  input  logic [RF_ADDR_W-1:0] d_rs2,
  input  logic                 d_use_rs1,
  input  logic                 d_use_rs2,
  input  logic [RF_ADDR_W-1:0] d_rd,
  input  logic                 d_reg_write,
  input  logic                 d_mem_read,
  input  logic                 d_mem_write,
  input  logic                 e_branch_taken,
  input  logic                 dmem_ready,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic                 freeze,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic [CNT_W-1:0]     cnt_stall,
  output logic [CNT_W-1:0]     cnt_flush,
  output logic [CNT_W-1:0]     cnt_retire
);

  hz_entry_t d_entry, e_q, m_q, w_q;
  logic      br, hazard;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A load in M has no data yet. Load-use stalls keep that case from
  // arising, so the load is skipped here and W is checked next.
  function automatic logic [1:0] fwd_sel(input hz_addr_t  src,
                                         input logic      use_src,
                                         input hz_entry_t m,
                                         input hz_entry_t w);
    if (raw_match(src, use_src, m) && !m.mem_read) return FWD_MEM;
    if (raw_match(src, use_src, w)) return FWD_WB;
    return FWD_NONE;
  endfunction

  always_comb begin
    d_entry           = '0;
    d_entry.valid     = d_valid;
    d_entry.rd        = hz_addr_t'(d_rd);
    d_entry.reg_write = d_reg_write;
    d_entry.mem_read  = d_mem_read;
    d_entry.mem_write = d_mem_write;
    d_entry.rs1       = hz_addr_t'(d_rs1);
    d_entry.rs2       = hz_addr_t'(d_rs2);
    d_entry.use_rs1   = d_use_rs1;
    d_entry.use_rs2   = d_use_rs2;
  end

  otter_hazard_sb u_sb (
    .clk     (CLK),
    .rst     (RST),
    .hold    (freeze),
    .bubble  (flush_e),
    .d_entry (d_entry),
    .e_q     (e_q),
    .m_q     (m_q),
    .w_q     (w_q)
  );

  // Stage boundary: decisions made from the scoreboard and the D fields
  assign freeze = m_q.valid & (m_q.mem_read | m_q.mem_write) & ~dmem_ready;
  assign br     = e_q.valid & e_branch_taken;

  always_comb begin
    hazard = 1'b0;
    if (ENABLE_FWD != 0) begin
      hazard = d_valid & e_q.mem_read &
               (raw_match(d_entry.rs1, d_use_rs1, e_q) |
                raw_match(d_entry.rs2, d_use_rs2, e_q));
    end else begin
      hazard = d_valid &
               (raw_match(d_entry.rs1, d_use_rs1, e_q) |
                raw_match(d_entry.rs2, d_use_rs2, e_q) |
                raw_match(d_entry.rs1, d_use_rs1, m_q) |
                raw_match(d_entry.rs2, d_use_rs2, m_q) |
                raw_match(d_entry.rs1, d_use_rs1, w_q) |
                raw_match(d_entry.rs2, d_use_rs2, w_q));
    end
  end

  // Priority order: freeze, then redirect, then dependency stall. A branch
  // held off by a freeze stays visible in E and acts once the freeze drops.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (freeze) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
    end else if (br) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (hazard) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // A bubble in E has no operands, so it gets no forwarding select
  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
    if ((ENABLE_FWD != 0) && e_q.valid) begin
      fwd_a = fwd_sel(e_q.rs1, e_q.use_rs1, m_q, w_q);
      fwd_b = fwd_sel(e_q.rs2, e_q.use_rs2, m_q, w_q);
    end
  end

  // Stage boundary: performance counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_stall  <= '0;
      cnt_flush  <= '0;
      cnt_retire <= '0;
    end else begin
      if (stall_d) cnt_stall <= sat_inc(cnt_stall);
      if (flush_d) cnt_flush <= sat_inc(cnt_flush);
      if (w_q.valid && !freeze) cnt_retire <= sat_inc(cnt_retire);
    end
  end

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Bench for otter_hazard_ctrl. Two instances share one random stimulus
// stream: one with forwarding and 4-bit counters, one without forwarding and
// with 32-bit counters. A reference model of the pipeline occupancy predicts
// each cycle's outputs into a queue. A monitor on the falling edge pops the
// queue and compares.
module tb_otter_hazard_ctrl;

  typedef struct {
    bit v;
    int rd;
    bit rw, mr, mw;
    int rs1, rs2;
    bit u1, u2;
  } ins_t;

  typedef struct {
    int     k;
    bit     sf, sd, fd, fe, fz;
    bit [1:0] fa, fb;
    longint cs, cf, cr;
  } exp_t;

  logic       CLK, RST;
  logic       d_valid, d_use_rs1, d_use_rs2, d_reg_write, d_mem_read, d_mem_write;
  logic [4:0] d_rs1, d_rs2, d_rd;
  logic       e_branch_taken, dmem_ready;

  logic        sf_f, sd_f, fd_f, fe_f, fz_f, sf_n, sd_n, fd_n, fe_n, fz_n;
  logic [1:0]  fa_f, fb_f, fa_n, fb_n;
  logic [3:0]  cs_f, cf_f, cr_f;
  logic [31:0] cs_n, cf_n, cr_n;

  otter_hazard_ctrl #(.RF_ADDR_W(5), .ENABLE_FWD(1), .CNT_W(4)) dut_f (
    .CLK(CLK), .RST(RST), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_rd(d_rd),
    .d_reg_write(d_reg_write), .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .e_branch_taken(e_branch_taken), .dmem_ready(dmem_ready),
    .stall_f(sf_f), .stall_d(sd_f), .flush_d(fd_f), .flush_e(fe_f), .freeze(fz_f),
    .fwd_a(fa_f), .fwd_b(fb_f), .cnt_stall(cs_f), .cnt_flush(cf_f), .cnt_retire(cr_f));

  otter_hazard_ctrl #(.RF_ADDR_W(5), .ENABLE_FWD(0), .CNT_W(32)) dut_n (
    .CLK(CLK), .RST(RST), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_rd(d_rd),
    .d_reg_write(d_reg_write), .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .e_branch_taken(e_branch_taken), .dmem_ready(dmem_ready),
    .stall_f(sf_n), .stall_d(sd_n), .flush_d(fd_n), .flush_e(fe_n), .freeze(fz_n),
    .fwd_a(fa_n), .fwd_b(fb_n), .cnt_stall(cs_n), .cnt_flush(cf_n), .cnt_retire(cr_n));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int     total = 0;
  int     bad   = 0;
  exp_t   q[$];

  // Model state: per instance k, slot 0 = E, 1 = M, 2 = W
  ins_t   pipe[2][3];
  longint cs[2], cf[2], cr[2];
  longint cmax[2];

  function automatic bit dep(int s, bit u, ins_t x);
    return u && (s != 0) && x.v && x.rw && (s == x.rd);
  endfunction

  function automatic bit [1:0] src_sel(int s, bit u, ins_t m, ins_t w);
    if (dep(s, u, m) && !m.mr) return 2'b10;
    if (dep(s, u, w)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic longint sat(longint v, longint mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic clear_model();
    ins_t z;
    z = '{default: 0};
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) pipe[k][s] = z;
      cs[k] = 0;
      cf[k] = 0;
      cr[k] = 0;
    end
  endtask

  task automatic check(string nm, int k, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s[%0d] t=%0t got=%0d want=%0d", nm, k, $time, act, req);
    end
  endtask

  // One clock cycle. Drive the inputs just after the rising edge. Push the
  // expected outputs for this cycle, then advance the model across the next
  // edge.
  task automatic step(bit rst_v, ins_t d, bit bt, bit rdy);
    @(posedge CLK);
    #1;
    RST            = rst_v;
    d_valid        = d.v;
    d_rd           = 5'(d.rd);
    d_rs1          = 5'(d.rs1);
    d_rs2          = 5'(d.rs2);
    d_use_rs1      = d.u1;
    d_use_rs2      = d.u2;
    d_reg_write    = d.rw;
    d_mem_read     = d.mr;
    d_mem_write    = d.mw;
    e_branch_taken = bt;
    dmem_ready     = rdy;
    if (rst_v) clear_model();
    for (int k = 0; k < 2; k++) begin
      ins_t e, m, w, z;
      bit   frz, br, hz;
      exp_t x;
      e = pipe[k][0];
      m = pipe[k][1];
      w = pipe[k][2];
      z = '{default: 0};
      frz = m.v && (m.mr || m.mw) && !rdy;
      br  = e.v && bt;
      hz  = 1'b0;
      if (k == 0) begin
        hz = d.v && e.v && e.mr && (dep(d.rs1, d.u1, e) || dep(d.rs2, d.u2, e));
      end else begin
        for (int s = 0; s < 3; s++)
          if (d.v && (dep(d.rs1, d.u1, pipe[k][s]) || dep(d.rs2, d.u2, pipe[k][s])))
            hz = 1'b1;
      end
      x = '{default: 0};
      x.k  = k;
      x.fz = frz;
      if (frz) begin
        x.sf = 1; x.sd = 1;
      end else if (br) begin
        x.fd = 1; x.fe = 1;
      end else if (hz) begin
        x.sf = 1; x.sd = 1; x.fe = 1;
      end
      if (k == 0 && e.v) begin
        x.fa = src_sel(e.rs1, e.u1, m, w);
        x.fb = src_sel(e.rs2, e.u2, m, w);
      end
      x.cs = cs[k];
      x.cf = cf[k];
      x.cr = cr[k];
      q.push_back(x);
      if (!rst_v) begin
        if (x.sd) cs[k] = sat(cs[k], cmax[k]);
        if (x.fd) cf[k] = sat(cf[k], cmax[k]);
        if (!frz) begin
          if (w.v) cr[k] = sat(cr[k], cmax[k]);
          pipe[k][2] = m;
          pipe[k][1] = e;
          pipe[k][0] = x.fe ? z : d;
        end
      end
    end
  endtask

  // Monitor: compare whatever the driver has predicted for this cycle
  initial begin
    exp_t x;
    forever begin
      @(negedge CLK);
      while (q.size() != 0) begin
        x = q.pop_front();
        if (x.k == 0) begin
          check("stall_f", 0, sf_f, x.sf);
          check("stall_d", 0, sd_f, x.sd);
          check("flush_d", 0, fd_f, x.fd);
          check("flush_e", 0, fe_f, x.fe);
          check("freeze", 0, fz_f, x.fz);
          check("fwd_a", 0, fa_f, x.fa);
          check("fwd_b", 0, fb_f, x.fb);
          check("cnt_stall", 0, cs_f, x.cs);
          check("cnt_flush", 0, cf_f, x.cf);
          check("cnt_retire", 0, cr_f, x.cr);
        end else begin
          check("stall_f", 1, sf_n, x.sf);
          check("stall_d", 1, sd_n, x.sd);
          check("flush_d", 1, fd_n, x.fd);
          check("flush_e", 1, fe_n, x.fe);
          check("freeze", 1, fz_n, x.fz);
          check("fwd_a", 1, fa_n, x.fa);
          check("fwd_b", 1, fb_n, x.fb);
          check("cnt_stall", 1, cs_n, x.cs);
          check("cnt_flush", 1, cf_n, x.cf);
          check("cnt_retire", 1, cr_n, x.cr);
        end
      end
    end
  end

  // Driver
  initial begin
    ins_t d, z;
    bit   bt, rdy;
    z       = '{default: 0};
    cmax[0] = 15;
    cmax[1] = 64'hFFFF_FFFF;
    clear_model();
    RST = 1'b1;
    d_valid = 0; d_rd = 0; d_rs1 = 0; d_rs2 = 0; d_use_rs1 = 0; d_use_rs2 = 0;
    d_reg_write = 0; d_mem_read = 0; d_mem_write = 0;
    e_branch_taken = 0; dmem_ready = 1;
    // Active inputs during reset must still yield all-zero outputs
    d = '{v: 1, rd: 5, rw: 1, mr: 1, mw: 0, rs1: 5, rs2: 5, u1: 1, u2: 1};
    step(1'b1, d, 1'b1, 1'b0);
    step(1'b1, d, 1'b1, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      d.v   = ($urandom % 8) != 0;
      d.rd  = int'($urandom % 8);
      d.rs1 = int'($urandom % 8);
      d.rs2 = int'($urandom % 8);
      d.u1  = ($urandom % 4) != 0;
      d.u2  = ($urandom % 2) != 0;
      d.rw  = ($urandom % 4) != 0;
      d.mr  = ($urandom % 4) == 0;
      d.mw  = !d.mr && (($urandom % 5) == 0);
      bt    = ($urandom % 6) == 0;
      rdy   = ($urandom % 4) != 0;
      // Periodic reset in the middle of traffic, held for two cycles
      step((i % 300) == 250 || (i % 300) == 251, d, bt, rdy);
    end
    step(1'b0, z, 1'b0, 1'b1);
    @(negedge CLK);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
